lipsi_mem_arbiter: RTL
======================

// Module: lipsi_mem_arbiter
// PURPOSE
//  Two-port arbiter and sequencer for the shared 256x8 Lipsi data memory.
//  Requester CPU is the lipsi_processor data path. Requester LDR is a program/data loader or debug port.
//  The block grants one single-port access per cycle and enforces a burst limit so neither side starves.
//  It owns the memory array and registers the read data.
// PARAMETERS
//  AW         8  address width; memory depth is 2**AW
//  DW         8  data width
//  MAX_BURST  4  max consecutive accesses by one owner while the other is requesting (>=1)
// PORTS
//  clk        in   1   system clock; single clock domain
//  reset      in   1   synchronous, active-high reset
//  cpu_req    in   1   CPU access request; level, held until served
//  cpu_we     in   1   1=write, 0=read
//  cpu_addr   in   AW  CPU address
//  cpu_wdata  in   DW  CPU write data
//  cpu_gnt    out  1   registered grant; access occurs on edge where cpu_gnt&&cpu_req
//  cpu_rvalid out  1   one-cycle pulse, read data valid
//  cpu_rdata  out  DW  registered read data
//  ldr_req    in   1   loader request (same rules as cpu_*)
//  ldr_we     in   1   loader write enable
//  ldr_addr   in   AW  loader address
//  ldr_wdata  in   DW  loader write data
//  ldr_gnt    out  1   loader grant
//  ldr_rvalid out  1   loader read-valid pulse
//  ldr_rdata  out  DW  loader read data
// BEHAVIOUR
//  - Reset: state=IDLE, burst_cnt=0, last_owner=LDR, all gnt=0, rvalid=0, rdata=0.
//    Memory contents are NOT cleared.
//  - Requesters hold req/we/addr/wdata stable from req rise until the edge with gnt=1.
//  - FSM states: IDLE, OWN_CPU, OWN_LDR. gnt_x=1 exactly in OWN_X; grants are one-hot or zero.
//  - IDLE:
//      none requesting -> IDLE
//      one requesting -> that owner
//      both requesting -> priority winner (see CONFIGURATION)
//  - OWN_X at each edge:
//      req_x=0 -> no access; go to OWN_other if req_other, else IDLE.
//      req_x=1 -> perform access this edge. Then:
//        if burst_cnt==MAX_BURST-1 and req_other -> OWN_other
//        else stay, burst_cnt++ (saturating)
//  - burst_cnt clears to 0 on every entry into an OWN state.
//  - last_owner updates on every performed access.
//  - Latency: grant 1 cycle after req from IDLE. Read data 1 cycle after the access edge.
//      Same owner: back-to-back accesses every cycle.
//  - Write: mem[addr]<=wdata; no rvalid.
//  - Read: rdata_x<=mem[addr], rvalid_x=1 for the next cycle only.
//      rdata_x holds its value until the next read by that requester.
//  - Only one access per edge, so there is no write/read collision. Addresses use full AW bits; no wrap logic.
//  - Reset mid-burst: next cycle gnt=0, rvalid=0, IDLE. Writes done before reset persist.
// CONFIGURATION
//  LIPSI_MEM_RR_EN defined:
//    IDLE tie-break and burst-end handover are round-robin; the requester != last_owner wins.
//    First contention after reset goes to CPU.
//  LIPSI_MEM_RR_EN undefined:
//    IDLE tie-break is fixed priority, CPU wins. MAX_BURST handover still applies.
// TESTING
//  1. Reset; cpu write 0x5A @0x10, then cpu read 0x10.
//     -> gnt 1 cycle after req; rvalid pulses 1 cycle after read edge; cpu_rdata=0x5A.
//  2. ldr writes 0xC7 @0x00 and 0x0A @0x01; cpu reads 0x00,0x01.
//     -> cpu_rdata 0xC7 then 0x0A, one per cycle.
//  3. Fixed priority, MAX_BURST=4, both req continuously from IDLE.
//     -> 4 cpu accesses, then 4 ldr, repeating; never both gnt.
//  4. LIPSI_MEM_RR_EN, MAX_BURST=1, both req continuously.
//     -> grants alternate CPU,LDR,CPU,... from first grant.
//  5. cpu_gnt=1 mid-burst, reset pulsed one cycle.
//     -> next cycle gnt=0, rvalid=0, rdata=0; re-read of earlier written address returns old value.
//  6. cpu_req dropped while cpu_gnt=1, ldr idle.
//     -> no memory access (readback unchanged), next state IDLE, cpu_gnt=0.

Source files
------------

// File: rtl/lipsi_mem_arbiter.sv
// lipsi_mem_arbiter: two-port burst-limited arbiter owning the Lipsi data memory; LIPSI_MEM_RR_EN selects round-robin tie-break
module lipsi_mem_arbiter #(
  parameter int AW = 8,
  parameter int DW = 8,
  parameter int MAX_BURST = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic          cpu_gnt,
  output logic          cpu_rvalid,
  output logic [DW-1:0] cpu_rdata,
  input  logic          ldr_req,
  input  logic          ldr_we,
  input  logic [AW-1:0] ldr_addr,
  input  logic [DW-1:0] ldr_wdata,
  output logic          ldr_gnt,
  output logic          ldr_rvalid,
  output logic [DW-1:0] ldr_rdata
);
  localparam int CW = MAX_BURST > 1 ? $clog2(MAX_BURST) : 1;
  typedef enum logic [1:0] {IDLE, OWN_CPU, OWN_LDR} state_t;
  state_t state, nxt;
  logic [CW-1:0] burst_cnt;
  logic last_ldr;
  logic [DW-1:0] mem [2**AW];
  logic cpu_acc, ldr_acc, top, cpu_first;
  assign cpu_acc = cpu_gnt && cpu_req;
  assign ldr_acc = ldr_gnt && ldr_req;
  assign top = burst_cnt == CW'(MAX_BURST - 1);
`ifdef LIPSI_MEM_RR_EN
  assign cpu_first = last_ldr;
`else
  assign cpu_first = 1'b1;
`endif
  always_comb begin
    nxt = state == IDLE ? (cpu_req && (!ldr_req || cpu_first) ? OWN_CPU : ldr_req ? OWN_LDR : IDLE)
        : state == OWN_CPU ? ((!cpu_req || top) && ldr_req ? OWN_LDR : cpu_req ? OWN_CPU : IDLE)
        : ((!ldr_req || top) && cpu_req ? OWN_CPU : ldr_req ? OWN_LDR : IDLE);
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      burst_cnt <= '0;
      last_ldr <= 1'b1;
      cpu_gnt <= 1'b0;
      ldr_gnt <= 1'b0;
      cpu_rvalid <= 1'b0;
      ldr_rvalid <= 1'b0;
      cpu_rdata <= '0;
      ldr_rdata <= '0;
    end else begin
      state <= nxt;
      cpu_gnt <= nxt == OWN_CPU;
      ldr_gnt <= nxt == OWN_LDR;
      burst_cnt <= (nxt != state || nxt == IDLE) ? '0 : top ? burst_cnt : burst_cnt + 1'b1;
      if (cpu_acc || ldr_acc) last_ldr <= ldr_acc;
      cpu_rvalid <= cpu_acc && !cpu_we;
      ldr_rvalid <= ldr_acc && !ldr_we;
      if (cpu_acc && !cpu_we) cpu_rdata <= mem[cpu_addr];
      if (ldr_acc && !ldr_we) ldr_rdata <= mem[ldr_addr];
    end
  end
  // grants are one-hot, so a single write port serves both requesters
  always_ff @(posedge clk) begin
    if (!reset && ((cpu_acc && cpu_we) || (ldr_acc && ldr_we)))
      mem[cpu_acc ? cpu_addr : ldr_addr] <= cpu_acc ? cpu_wdata : ldr_wdata;
  end
endmodule
